// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and helpers for the streaming comparator window block.
//   state_t  - window FSM state (S_EMPTY: no pair in current window, S_ACC: accumulating)
//   cmp3     - three-way compare of two pre-extended operands, returns CMP_GT/CMP_LT/CMP_EQ
//   REL_*    - one-hot {gt,lt,eq} relation codes as carried between mag_cmp and the top
package cmp_pkg;

  typedef enum logic {S_EMPTY, S_ACC} state_t;

  // Operands are widened to CMP_MAX_W+1 bits before cmp3 so one function serves any WIDTH.
  localparam int CMP_MAX_W = 64;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  localparam logic [2:0] REL_GT = 3'b100;
  localparam logic [2:0] REL_LT = 3'b010;

  function automatic logic [1:0] cmp3(input logic [CMP_MAX_W:0] a,
                                      input logic [CMP_MAX_W:0] b,
                                      input logic               sgn);
    logic is_gt;
    logic is_lt;
    if (sgn) begin
      is_gt = $signed(a) > $signed(b);
      is_lt = $signed(a) < $signed(b);
    end else begin
      is_gt = a > b;
      is_lt = a < b;
    end
    if (is_gt)      return CMP_GT;
    else if (is_lt) return CMP_LT;
    else            return CMP_EQ;
  endfunction

endpackage

// File: rtl/cmp_stream_window_mag_cmp.sv
// mag_cmp: combinational magnitude comparator, signed or unsigned per call.
//   a, b         - WIDTH-bit operands
//   signed_mode  - 1: two's complement, 0: unsigned
//   gt, lt, eq   - one-hot relation of a to b
module mag_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  logic [CMP_MAX_W:0] a_ext;
  logic [CMP_MAX_W:0] b_ext;
  logic [1:0]         code;

  // Sign- or zero-extend to the common width so cmp3 sees the intended numeric value.
  always_comb begin
    a_ext = signed_mode ? {{(CMP_MAX_W+1-WIDTH){a[WIDTH-1]}}, a}
                        : {{(CMP_MAX_W+1-WIDTH){1'b0}}, a};
    b_ext = signed_mode ? {{(CMP_MAX_W+1-WIDTH){b[WIDTH-1]}}, b}
                        : {{(CMP_MAX_W+1-WIDTH){1'b0}}, b};
    code  = cmp3(a_ext, b_ext, signed_mode);
  end

  assign gt = (code == CMP_GT);
  assign lt = (code == CMP_LT);
  assign eq = (code == CMP_EQ);

endmodule

// File: rtl/cmp_stream_window.sv
// cmp_stream_window: one-stage pipelined A/B comparator stream with windowed stats.
//   clk, rst_n            - clock, async active-low reset
//   in_valid/in_ready     - input handshake for a, b, signed_mode
//   clr                   - synchronous window restart (win_* untouched)
//   out_valid/out_ready   - result handshake for gt/lt/eq (zero when !out_valid)
//   win_done              - one-cycle pulse when a WIN_LEN-pair window closes
//   win_max/win_min       - max/min of A over the last closed window
//   gt_count              - number of A>B pairs in the last closed window
module cmp_stream_window
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int WIN_LEN = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           signed_mode,
  input  logic                           clr,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           gt,
  output logic                           lt,
  output logic                           eq,
  output logic                           win_done,
  output logic [WIDTH-1:0]               win_max,
  output logic [WIDTH-1:0]               win_min,
  output logic [$clog2(WIN_LEN+1)-1:0]   gt_count
);

  localparam int NUM_CMP = 3;
  localparam int CNT_W   = $clog2(WIN_LEN+1);

  // Comparator lanes: 0 = a vs b, 1 = a vs run_max, 2 = a vs run_min.
  logic [NUM_CMP-1:0][WIDTH-1:0] lhs;
  logic [NUM_CMP-1:0][WIDTH-1:0] rhs;
  logic [NUM_CMP-1:0][2:0]       rel;

  logic             accept;
  logic [2:0]       res;

  state_t           state, state_nx;
  logic [CNT_W-1:0] idx, idx_nx;
  logic [WIDTH-1:0] run_max, max_nx;
  logic [WIDTH-1:0] run_min, min_nx;
  logic [CNT_W-1:0] run_cnt, cnt_nx;
  logic             close;
  logic             gt_ab;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign lhs = {a, a, a};
  assign rhs = {run_min, run_max, b};

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
    mag_cmp #(.WIDTH(WIDTH)) u_cmp (
      .a           (lhs[i]),
      .b           (rhs[i]),
      .signed_mode (signed_mode),
      .gt          (rel[i][2]),
      .lt          (rel[i][1]),
      .eq          (rel[i][0])
    );
  end

  assign gt_ab = (rel[0] == REL_GT);

  // Result stage: new pair replaces the held one only when the consumer has taken it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      res       <= rel[0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign gt = out_valid & res[2];
  assign lt = out_valid & res[1];
  assign eq = out_valid & res[0];

  // Window FSM. clr with a simultaneous accept restarts with that pair as the first sample.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    max_nx   = run_max;
    min_nx   = run_min;
    cnt_nx   = run_cnt;
    close    = 1'b0;
    if (accept && (clr || state == S_EMPTY)) begin
      state_nx = S_ACC;
      idx_nx   = CNT_W'(1);
      max_nx   = a;
      min_nx   = a;
      cnt_nx   = CNT_W'(gt_ab);
    end else if (clr) begin
      state_nx = S_EMPTY;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else if (accept) begin
      if (rel[1] == REL_GT) max_nx = a;
      if (rel[2] == REL_LT) min_nx = a;
      cnt_nx = run_cnt + CNT_W'(gt_ab);
      idx_nx = idx + CNT_W'(1);
      if (idx == CNT_W'(WIN_LEN-1)) begin
        close    = 1'b1;
        state_nx = S_EMPTY;
        idx_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_EMPTY;
      idx     <= '0;
      run_max <= '0;
      run_min <= '0;
      run_cnt <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      run_max <= max_nx;
      run_min <= min_nx;
      run_cnt <= cnt_nx;
    end
  end

  // Published stats move on the same edge as the closing pair's result, so win_done
  // lines up with that pair's out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_done <= 1'b0;
      win_max  <= '0;
      win_min  <= '0;
      gt_count <= '0;
    end else begin
      win_done <= close;
      if (close) begin
        win_max  <= max_nx;
        win_min  <= min_nx;
        gt_count <= cnt_nx;
      end
    end
  end

endmodule

// File: tb/tb_cmp_stream_window.sv
module tb_cmp_stream_window;

  localparam int WIDTH   = 8;
  localparam int WIN_LEN = 4;
  localparam int CNT_W   = $clog2(WIN_LEN+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             signed_mode, clr;
  logic             out_valid, out_ready;
  logic             gt, lt, eq, win_done;
  logic [WIDTH-1:0] win_max, win_min;
  logic [CNT_W-1:0] gt_count;

  always #5 clk = ~clk;

  cmp_stream_window #(.WIDTH(WIDTH), .WIN_LEN(WIN_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .gt(gt), .lt(lt), .eq(eq), .win_done(win_done),
    .win_max(win_max), .win_min(win_min), .gt_count(gt_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, want);
  endtask

  function automatic logic grt(input logic [7:0] x, input logic [7:0] y, input logic s);
    return s ? ($signed(x) > $signed(y)) : (x > y);
  endfunction

  function automatic logic [2:0] exp_rel(input logic [7:0] x, input logic [7:0] y, input logic s);
    return {grt(x, y, s), grt(y, x, s), x == y};
  endfunction

  typedef struct packed {
    logic [7:0]       mx;
    logic [7:0]       mn;
    logic [CNT_W-1:0] cnt;
  } win_t;

  logic [2:0] exp_q[$];
  win_t       win_q[$];

  // Scoreboard: checks what the DUT shows now, then predicts the coming edge.
  initial begin : mon
    win_t       w;
    logic [7:0] m_max, m_min;
    int         m_cnt, m_idx;
    logic       done_next;
    m_max = 0; m_min = 0; m_cnt = 0; m_idx = 0; done_next = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); win_q.delete(); m_idx = 0; done_next = 0;
      end else begin
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (out_valid && exp_q.size() > 0) begin
          chk("sb_result", 32'({gt, lt, eq}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end else if (!out_valid) begin
          chk("idle_zero", 32'({gt, lt, eq}), 32'(0));
        end
        chk("win_done", 32'(win_done), 32'(done_next));
        if (win_done && win_q.size() > 0) begin
          w = win_q.pop_front();
          chk("sb_win_max", 32'(win_max), 32'(w.mx));
          chk("sb_win_min", 32'(win_min), 32'(w.mn));
          chk("sb_gt_count", 32'(gt_count), 32'(w.cnt));
        end
        done_next = 0;
        if (in_valid && in_ready) begin
          exp_q.push_back(exp_rel(a, b, signed_mode));
          if (clr || m_idx == 0) begin
            m_max = a; m_min = a; m_cnt = int'(grt(a, b, signed_mode)); m_idx = 1;
          end else begin
            if (grt(a, m_max, signed_mode)) m_max = a;
            if (grt(m_min, a, signed_mode)) m_min = a;
            m_cnt += int'(grt(a, b, signed_mode));
            m_idx++;
          end
          if (m_idx == WIN_LEN) begin
            win_q.push_back('{mx: m_max, mn: m_min, cnt: CNT_W'(m_cnt)});
            m_idx = 0;
            done_next = 1;
          end
        end else if (clr) begin
          m_idx = 0;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the pair.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                      input logic tclr = 1'b0);
    int   n;
    logic acc;
    n = 0; acc = 0;
    a = ta; b = tb_v; signed_mode = ts; clr = tclr; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; clr = 1'b0;
    chk("send_accepted", 32'(acc), 32'(1));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [2:0] rel;
  } vec_t;

  vec_t vt[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'hF0, 8'h10, 1'b0, 3'b100};
    vt[1] = '{8'h10, 8'h10, 1'b0, 3'b001};
    vt[2] = '{8'h01, 8'h80, 1'b0, 3'b010};
    vt[3] = '{8'hF0, 8'h10, 1'b1, 3'b010};
    vt[4] = '{8'h80, 8'h7F, 1'b1, 3'b010};
    vt[5] = '{8'h7F, 8'h80, 1'b1, 3'b100};
    vt[6] = '{8'hFF, 8'hFF, 1'b1, 3'b001};
    vt[7] = '{8'h00, 8'hFF, 1'b1, 3'b100};
    vt[8] = '{8'h00, 8'hFF, 1'b0, 3'b010};

    rst_n = 0; in_valid = 0; a = 0; b = 0; signed_mode = 0; clr = 0; out_ready = 1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_rel", 32'({gt, lt, eq, win_done}), 32'(0));
    chk("rst_win", 32'({win_max, win_min, gt_count}), 32'(0));
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // Table-driven single-pair compares.
    for (int i = 0; i < 9; i++) begin
      send(vt[i].a, vt[i].b, vt[i].s);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(1));
      chk($sformatf("vec%0d_rel", i), 32'({gt, lt, eq}), 32'(vt[i].rel));
      @(posedge clk); #1;
    end

    // Window of four unsigned pairs.
    clr = 1; @(posedge clk); #1 clr = 0;
    send(8'd5, 8'd6, 0); send(8'd200, 8'd6, 0); send(8'd7, 8'd6, 0); send(8'd3, 8'd6, 0);
    @(negedge clk);
    chk("w1_done", 32'(win_done), 32'(1));
    chk("w1_max", 32'(win_max), 32'(200));
    chk("w1_min", 32'(win_min), 32'(3));
    chk("w1_cnt", 32'(gt_count), 32'(2));
    @(posedge clk); #1;

    // Backpressure: first result held three cycles while a second pair waits.
    out_ready = 0;
    send(8'h30, 8'h20, 0);
    a = 8'h11; b = 8'h22; signed_mode = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_hold", 32'({out_valid, gt, lt, eq}), 32'(4'b1100));
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("bp_second", 32'({out_valid, gt, lt, eq}), 32'(4'b1010));
    @(posedge clk); #1;

    // clr together with the second accept of a window.
    clr = 1; @(posedge clk); #1 clr = 0;
    send(8'd250, 8'd25, 0);
    send(8'd10, 8'd25, 0, 1'b1);
    send(8'd20, 8'd25, 0);
    send(8'd30, 8'd25, 0);
    @(negedge clk);
    chk("clr_not_done", 32'(win_done), 32'(0));
    chk("clr_held_max", 32'(win_max), 32'(200));
    chk("clr_held_cnt", 32'(gt_count), 32'(2));
    @(posedge clk); #1;
    send(8'd40, 8'd25, 0);
    @(negedge clk);
    chk("clr_done", 32'(win_done), 32'(1));
    chk("clr_max", 32'(win_max), 32'(40));
    chk("clr_min", 32'(win_min), 32'(10));
    chk("clr_cnt", 32'(gt_count), 32'(2));
    @(posedge clk); #1;

    // Async reset mid-window while a result is stalled.
    send(8'd100, 8'd1, 0);
    send(8'd101, 8'd1, 0);
    send(8'd5, 8'd6, 0);
    out_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'(0));
    chk("arst_rel", 32'({gt, lt, eq, win_done}), 32'(0));
    chk("arst_win", 32'({win_max, win_min, gt_count}), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    out_ready = 1;
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    send(8'd100, 8'd100, 0); send(8'd50, 8'd100, 0); send(8'd150, 8'd100, 0); send(8'd1, 8'd100, 0);
    @(negedge clk);
    chk("post_rst_done", 32'(win_done), 32'(1));
    chk("post_rst_max", 32'(win_max), 32'(150));
    chk("post_rst_min", 32'(win_min), 32'(1));
    chk("post_rst_cnt", 32'(gt_count), 32'(1));

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size() + win_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
